// File: rtl/holy_core_pkg.sv
// rtl/holy_core_pkg.sv - shared FSM encodings and port indices for the core AXI arbiter
package holy_core_pkg;

    typedef logic [1:0] arb_rd_state_t;
    localparam arb_rd_state_t R_IDLE = 2'd0;
    localparam arb_rd_state_t R_ARB  = 2'd1;
    localparam arb_rd_state_t R_ADDR = 2'd2;
    localparam arb_rd_state_t R_DATA = 2'd3;

    typedef logic [2:0] arb_wr_state_t;
    localparam arb_wr_state_t W_IDLE = 3'd0;
    localparam arb_wr_state_t W_ARB  = 3'd1;
    localparam arb_wr_state_t W_ADDR = 3'd2;
    localparam arb_wr_state_t W_DATA = 3'd3;
    localparam arb_wr_state_t W_RESP = 3'd4;

    localparam logic ICACHE_PORT = 1'b0;
    localparam logic DCACHE_PORT = 1'b1;

endpackage

// File: rtl/holy_rr_arbiter_2.sv
// rtl/holy_rr_arbiter_2.sv - two-input round-robin picker
// req    : request vector, bit N from master N
// last   : index of the master granted most recently
// winner : index chosen for the next grant (meaningless when req == 0)
module holy_rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            // contention: the master that did not win last time goes first
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/holy_axi_arbiter.sv
// rtl/holy_axi_arbiter.sv - 2:1 AXI4 arbiter sharing the core's external port between icache and dcache
// clk, rst          : core/AXI clock, asynchronous active-high reset
// s0_* / s1_*       : slave side of the icache (0) and dcache (1) master ports
// m_*               : master side toward the SoC interconnect
// rd_owner/wr_owner : {valid, index} of the current read / write grant
module holy_axi_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int RESET_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    // master 0 (icache)
    input  logic [3:0]  s0_arid,
    input  logic [31:0] s0_araddr,
    input  logic [7:0]  s0_arlen,
    input  logic [2:0]  s0_arsize,
    input  logic [1:0]  s0_arburst,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    output logic [3:0]  s0_rid,
    output logic [31:0] s0_rdata,
    output logic [1:0]  s0_rresp,
    output logic        s0_rlast,
    output logic        s0_rvalid,
    input  logic        s0_rready,
    input  logic [3:0]  s0_awid,
    input  logic [31:0] s0_awaddr,
    input  logic [7:0]  s0_awlen,
    input  logic [2:0]  s0_awsize,
    input  logic [1:0]  s0_awburst,
    input  logic        s0_awvalid,
    output logic        s0_awready,
    input  logic [31:0] s0_wdata,
    input  logic [3:0]  s0_wstrb,
    input  logic        s0_wlast,
    input  logic        s0_wvalid,
    output logic        s0_wready,
    output logic [3:0]  s0_bid,
    output logic [1:0]  s0_bresp,
    output logic        s0_bvalid,
    input  logic        s0_bready,
    // master 1 (dcache)
    input  logic [3:0]  s1_arid,
    input  logic [31:0] s1_araddr,
    input  logic [7:0]  s1_arlen,
    input  logic [2:0]  s1_arsize,
    input  logic [1:0]  s1_arburst,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    output logic [3:0]  s1_rid,
    output logic [31:0] s1_rdata,
    output logic [1:0]  s1_rresp,
    output logic        s1_rlast,
    output logic        s1_rvalid,
    input  logic        s1_rready,
    input  logic [3:0]  s1_awid,
    input  logic [31:0] s1_awaddr,
    input  logic [7:0]  s1_awlen,
    input  logic [2:0]  s1_awsize,
    input  logic [1:0]  s1_awburst,
    input  logic        s1_awvalid,
    output logic        s1_awready,
    input  logic [31:0] s1_wdata,
    input  logic [3:0]  s1_wstrb,
    input  logic        s1_wlast,
    input  logic        s1_wvalid,
    output logic        s1_wready,
    output logic [3:0]  s1_bid,
    output logic [1:0]  s1_bresp,
    output logic        s1_bvalid,
    input  logic        s1_bready,
    // shared downstream port
    output logic [3:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [3:0]  m_rid,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [3:0]  m_awid,
    output logic [31:0] m_awaddr,
    output logic [7:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [3:0]  m_bid,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    // debug
    output logic [1:0]  rd_owner,
    output logic [1:0]  wr_owner
);

    import holy_core_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);
    // pointer starts at the "other" master so RESET_PRIO wins the first tie
    localparam logic [IDX_W-1:0] RST_LAST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

    arb_rd_state_t    rd_state_q, rd_state_d;
    logic [IDX_W-1:0] rd_sel_q, rd_sel_d, rd_last_q, rd_last_d, rd_win;
    arb_wr_state_t    wr_state_q, wr_state_d;
    logic [IDX_W-1:0] wr_sel_q, wr_sel_d, wr_last_q, wr_last_d, wr_win;

    logic rd_to_s1, wr_to_s1;
    logic ar_hs, r_hs_last, aw_hs, w_hs_last, b_hs;

    holy_rr_arbiter_2 u_rd_rr (
        .req    ({s1_arvalid, s0_arvalid}),
        .last   (rd_last_q),
        .winner (rd_win)
    );

    holy_rr_arbiter_2 u_wr_rr (
        .req    ({s1_awvalid, s0_awvalid}),
        .last   (wr_last_q),
        .winner (wr_win)
    );

    assign rd_to_s1 = (rd_sel_q == DCACHE_PORT);
    assign wr_to_s1 = (wr_sel_q == DCACHE_PORT);

    // raw handshakes from the granted master; only acted on in the matching state
    assign ar_hs     = m_arready && (rd_to_s1 ? s1_arvalid : s0_arvalid);
    assign r_hs_last = m_rvalid && m_rlast && (rd_to_s1 ? s1_rready : s0_rready);
    assign aw_hs     = m_awready && (wr_to_s1 ? s1_awvalid : s0_awvalid);
    assign w_hs_last = m_wready && (wr_to_s1 ? (s1_wvalid && s1_wlast) : (s0_wvalid && s0_wlast));
    assign b_hs      = m_bvalid && (wr_to_s1 ? s1_bready : s0_bready);

    // request payloads follow the grant unconditionally; only the valids are gated
    assign m_arid    = rd_to_s1 ? s1_arid    : s0_arid;
    assign m_araddr  = rd_to_s1 ? s1_araddr  : s0_araddr;
    assign m_arlen   = rd_to_s1 ? s1_arlen   : s0_arlen;
    assign m_arsize  = rd_to_s1 ? s1_arsize  : s0_arsize;
    assign m_arburst = rd_to_s1 ? s1_arburst : s0_arburst;
    assign m_awid    = wr_to_s1 ? s1_awid    : s0_awid;
    assign m_awaddr  = wr_to_s1 ? s1_awaddr  : s0_awaddr;
    assign m_awlen   = wr_to_s1 ? s1_awlen   : s0_awlen;
    assign m_awsize  = wr_to_s1 ? s1_awsize  : s0_awsize;
    assign m_awburst = wr_to_s1 ? s1_awburst : s0_awburst;
    assign m_wdata   = wr_to_s1 ? s1_wdata   : s0_wdata;
    assign m_wstrb   = wr_to_s1 ? s1_wstrb   : s0_wstrb;
    assign m_wlast   = wr_to_s1 ? s1_wlast   : s0_wlast;

    assign rd_owner = (rd_state_q == R_IDLE) ? 2'b00 : {1'b1, rd_sel_q};
    assign wr_owner = (wr_state_q == W_IDLE) ? 2'b00 : {1'b1, wr_sel_q};

    always_comb begin
        rd_state_d = rd_state_q;
        rd_sel_d   = rd_sel_q;
        rd_last_d  = rd_last_q;
        m_arvalid  = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        m_rready   = 1'b0;
        s0_rid = '0; s0_rdata = '0; s0_rresp = '0; s0_rlast = 1'b0; s0_rvalid = 1'b0;
        s1_rid = '0; s1_rdata = '0; s1_rresp = '0; s1_rlast = 1'b0; s1_rvalid = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (s0_arvalid || s1_arvalid) begin
                    rd_sel_d   = rd_win;
                    rd_state_d = R_ARB;
                end
            end
            R_ARB: rd_state_d = R_ADDR;
            R_ADDR: begin
                m_arvalid  = rd_to_s1 ? s1_arvalid : s0_arvalid;
                s0_arready = !rd_to_s1 && m_arready;
                s1_arready =  rd_to_s1 && m_arready;
                if (ar_hs) begin
                    rd_state_d = R_DATA;
                    rd_last_d  = rd_sel_q;
                end
            end
            R_DATA: begin
                if (rd_to_s1) begin
                    s1_rid = m_rid; s1_rdata = m_rdata; s1_rresp = m_rresp;
                    s1_rlast = m_rlast; s1_rvalid = m_rvalid;
                    m_rready = s1_rready;
                end else begin
                    s0_rid = m_rid; s0_rdata = m_rdata; s0_rresp = m_rresp;
                    s0_rlast = m_rlast; s0_rvalid = m_rvalid;
                    m_rready = s0_rready;
                end
                if (r_hs_last) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_sel_d   = wr_sel_q;
        wr_last_d  = wr_last_q;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        s0_awready = 1'b0;
        s1_awready = 1'b0;
        s0_wready  = 1'b0;
        s1_wready  = 1'b0;
        s0_bid = '0; s0_bresp = '0; s0_bvalid = 1'b0;
        s1_bid = '0; s1_bresp = '0; s1_bvalid = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (s0_awvalid || s1_awvalid) begin
                    wr_sel_d   = wr_win;
                    wr_state_d = W_ARB;
                end
            end
            W_ARB: wr_state_d = W_ADDR;
            W_ADDR: begin
                m_awvalid  = wr_to_s1 ? s1_awvalid : s0_awvalid;
                s0_awready = !wr_to_s1 && m_awready;
                s1_awready =  wr_to_s1 && m_awready;
                if (aw_hs) begin
                    wr_state_d = W_DATA;
                    wr_last_d  = wr_sel_q;
                end
            end
            W_DATA: begin
                m_wvalid  = wr_to_s1 ? s1_wvalid : s0_wvalid;
                s0_wready = !wr_to_s1 && m_wready;
                s1_wready =  wr_to_s1 && m_wready;
                if (w_hs_last) wr_state_d = W_RESP;
            end
            W_RESP: begin
                if (wr_to_s1) begin
                    s1_bid = m_bid; s1_bresp = m_bresp; s1_bvalid = m_bvalid;
                    m_bready = s1_bready;
                end else begin
                    s0_bid = m_bid; s0_bresp = m_bresp; s0_bvalid = m_bvalid;
                    m_bready = s0_bready;
                end
                if (b_hs) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_sel_q   <= '0;
            rd_last_q  <= RST_LAST;
            wr_state_q <= W_IDLE;
            wr_sel_q   <= '0;
            wr_last_q  <= RST_LAST;
        end else begin
            rd_state_q <= rd_state_d;
            rd_sel_q   <= rd_sel_d;
            rd_last_q  <= rd_last_d;
            wr_state_q <= wr_state_d;
            wr_sel_q   <= wr_sel_d;
            wr_last_q  <= wr_last_d;
        end
    end

endmodule

// File: doc/holy_axi_arbiter.md
Name: holy_axi_arbiter

Overview:
- Two-master to one-slave AXI4 full arbiter that shares the core's single external AXI port between the instruction cache (master 0) and the data cache (master 1).
- Sits between the two cache `axi_if` master ports and the SoC interconnect.
- Read and write paths are arbitrated independently.
- Each path is granted per burst and held until that burst's final response, so beats from different masters never interleave.

Parameters:
- NUM_PORTS, 2, number of requesters; fixed at 2, with arbitration logic written for 2.
- RESET_PRIO, 0, master that wins the first simultaneous request after reset.

Ports:
- clk  in  1  core clock; also AXI clock, one domain.
- rst  in  1  asynchronous, active-high reset.
- s0  axi_if slave modport  -  instruction-cache master port (AW/W/B/AR/R, 32-bit addr/data, 4-bit id).
- s1  axi_if slave modport  -  data-cache master port.
- m  axi_if master modport  -  shared downstream port.
- rd_owner  out  2  debug: {valid, index} of the current read grant.
- wr_owner  out  2  debug: {valid, index} of the current write grant.

Behaviour:
- Read FSM states: R_IDLE, R_ARB, R_ADDR, R_DATA.
  - R_IDLE: if any sN.arvalid, register winner into rd_sel and go to R_ARB.
    - Only one requesting: that one wins.
    - Both requesting: winner is the master not granted last (round-robin pointer rd_last, reset to ~RESET_PRIO).
  - R_ARB: one settle cycle; go to R_ADDR.
  - R_ADDR: m.ar* = s[rd_sel].ar*; s[rd_sel].arready = m.arready.
    - On m.arvalid & m.arready: go to R_DATA and set rd_last = rd_sel.
  - R_DATA: m.r* routed to s[rd_sel]; m.rready = s[rd_sel].rready.
    - On rvalid & rready & rlast: go to R_IDLE.
- Write FSM states: W_IDLE, W_ARB, W_ADDR, W_DATA, W_RESP. Same rules, using wr_sel/wr_last.
  - W_ADDR: forward aw*. Leave on AW handshake.
  - W_DATA: forward w*. Leave on a W handshake with wlast.
  - W_RESP: forward b*. Leave on B handshake, to W_IDLE.
  - AW and W are serialized; the caches issue AW before W, and this is required of the masters.
- Non-granted masters see arready/awready/wready/rvalid/bvalid = 0.
  - Their r*/b* data buses are driven 0, not muxed.
- When not in R_ADDR, m.arvalid = 0. The same holds for awvalid outside W_ADDR and wvalid outside W_DATA.
- In idle states m.rready = 0 and m.bready = 0.
- Minimum latency: sN.arvalid high in cycle T (FSM in R_IDLE) → m.arvalid in cycle T+2. Data path adds zero latency (combinational mux).
- The grant is held for the full burst. A higher-priority arrival mid-burst has no effect until return to idle.
- Back-to-back request: R_DATA→R_IDLE on rlast in cycle T.
  - New arbitration happens in cycle T+1.
  - Round-robin gives the other master priority if both are waiting.
- ID fields pass through unmodified. Slave responses are routed purely by rd_sel/wr_sel, never by rid/bid.
- Reset mid-burst: both FSMs go to idle, pointers go to ~RESET_PRIO, all forwarded valids/readies drop to 0 asynchronously. Recovering the external slave is not this block's concern.
- Reset values: all m.*valid, m.rready, m.bready = 0; all sN.*ready and sN.*valid = 0; rd_owner = wr_owner = 2'b00.
- Masters must keep arvalid/awvalid asserted until accepted, per AXI. Dropping a request during R_ARB is a protocol violation, and the bench asserts on it.

Decomposition:
- holy_core_pkg gains:
  - arb_rd_state_t (R_IDLE, R_ARB, R_ADDR, R_DATA)
  - arb_wr_state_t (W_IDLE, W_ARB, W_ADDR, W_DATA, W_RESP)
  - localparam ICACHE_PORT = 0, DCACHE_PORT = 1
- Natural sub-module: holy_rr_arbiter_2. It is a 2-input round-robin picker (req[1:0], last, winner) instantiated once per path.
- A testbench wrapper flattens the three axi_if ports to discrete signals for cocotb.

Test Plan:
- s0 single AR (addr 0x0000_1000, len 7), s1 idle → m.araddr = 0x1000 two cycles later; 8 R beats reach s0 only, s1.rvalid stays 0; rd_owner = 2'b10 during the burst.
- s0 and s1 assert arvalid in the same cycle after reset → s0 granted first (RESET_PRIO = 0). After its rlast, s1 is granted; both s1 arvalid and s1 arready must be observed.
- s1 write burst (awlen 3, wstrb 4'hF, data 0xA5A5_0001..4) with m.wready toggling 1-0-1-0 → 4 beats in order, wlast on beat 4; s1 gets bresp = 2'b00; s0.bvalid stays 0.
- Concurrent: s0 read burst and s1 write burst in flight simultaneously → both complete independently; no cycle stalls either path due to the other.
- Round-robin fairness: both masters continuously request 6 reads (len 0) → grant sequence 0,1,0,1,0,1.
- rst asserted during an R_DATA beat 3 of 8 → m.arvalid/m.rready and s0.rvalid go 0 immediately; after release, a new s1 request is granted normally.
